// File: rtl/ps2_pkg.sv
// Shared PS/2 receive constants and types, also used by the downstream scan-code display logic.
package ps2_pkg;

    localparam int FRAME_BITS = 11;

    typedef logic [7:0] scan_code_t;

    localparam scan_code_t BREAK_CODE = 8'hF0;
    localparam scan_code_t EXT_CODE   = 8'hE0;

    // Returns the parity bit that makes data plus parity hold an odd number of ones.
    function automatic logic odd_parity(input scan_code_t code);
        return ~(^code);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous receive FIFO; pointers carry one extra wrap bit to separate full from empty.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_pop;
    logic          w_push;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a write while full is still accepted.
    assign w_push = push & (~full | w_pop);
    assign rdata  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= wdata;
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizer, 11-bit frame shifter, timeout and receive FIFO.
// Define PS2_RX_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]            r_clk_sync;
    logic [2:0]            r_data_sync;
    logic [3:0]            r_bit_cnt;
    logic [9:0]            r_shift;
    logic [TW-1:0]         r_timeout;
    logic                  r_overflow;
    logic                  r_frame_err;
    logic                  w_sample;
    logic                  w_bit;
    logic                  w_timeout;
    logic                  w_frame_end;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_par_ok;
    logic                  w_frame_ok;
    logic                  w_full;
    logic                  w_empty;
    scan_code_t            w_head;

    assign w_sample    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit       = r_data_sync[1];
    assign w_timeout   = (r_timeout == TW'(TIMEOUT_CYC));
    assign w_frame_end = w_sample && (r_bit_cnt == 4'd10);
    assign w_frame     = {w_bit, r_shift};

`ifdef PS2_RX_PARITY_CHECK_EN
    assign w_par_ok = ^w_frame[9:1];
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_frame_ok = w_frame_end && !w_frame[0] && w_frame[10] && w_par_ok;

    // Three-flop synchronizers, idling high like the open-collector bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 3'b111;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
            r_data_sync <= {r_data_sync[1:0], ps2_data};
        end
    end

    // Frame shifter; after ten shifts r_shift[0] holds the start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 10'd0;
        end else if (w_sample) begin
            if (r_bit_cnt == 4'd10) begin
                r_bit_cnt <= 4'd0;
            end else begin
                r_shift   <= {w_bit, r_shift[9:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end else if (w_timeout) begin
            r_bit_cnt <= 4'd0;
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Inactivity timer; only runs while a frame is partially received.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= '0;
        end else if (w_sample || (r_bit_cnt == 4'd0) || w_timeout) begin
            r_timeout <= '0;
        end else begin
            r_timeout <= r_timeout + TW'(1);
        end
    end

    // Error pulse and sticky drop flag; a full FIFO only drops when no pop frees a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_frame_end && !w_frame_ok;
            if (w_frame_ok && w_full && nextdata_n) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_frame_ok),
        .pop   (~nextdata_n),
        .wdata (w_frame[8:1]),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign data      = w_head;
    assign ready     = ~w_empty;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed scoreboard bench for ps2_rx with a shortened timeout.
module tb_ps2_rx;

    localparam int DEPTH = 8;
    localparam int TOUT  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int err_cycles = 0;
    logic [7:0] exp_q[$];

    ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            wait_clk(4);
            ps2_clk = 1'b0;
            wait_clk(8);
            ps2_clk = 1'b1;
            wait_clk(4);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bits({stop, par, b, 1'b0}, 11);
    endtask

    // Good frame: odd parity, stop 1; scoreboard records it when it should land in the FIFO.
    task automatic send_good(input logic [7:0] b, input logic expect_store);
        send_frame(b, ~(^b), 1'b1);
        if (expect_store) exp_q.push_back(b);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
            chk({tag, "_data"}, {24'd0, data}, {24'd0, e});
        end
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    initial begin
        int err_base;

        wait_clk(3);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'h00);
        rst = 1'b0;
        wait_clk(2);

        // Single frame, then pop; pop request while empty is ignored.
        send_good(8'h1C, 1'b1);
        pop_check("single");
        chk("single_empty", {31'd0, ready}, 32'd0);
        nextdata_n = 1'b0;
        wait_clk(2);
        nextdata_n = 1'b1;
        chk("pop_when_empty", {31'd0, ready}, 32'd0);

        // Three frames in order.
        send_good(8'h1C, 1'b1);
        send_good(8'hF0, 1'b1);
        send_good(8'h1C, 1'b1);
        for (int i = 0; i < 3; i++) pop_check("three");
        chk("three_empty", {31'd0, ready}, 32'd0);

        // Nine frames into depth 8: ninth dropped, overflow set.
        for (int i = 1; i <= 9; i++) send_good(8'(i), (i <= DEPTH) ? 1'b1 : 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check("ovf_pop");
        chk("ovf_empty", {31'd0, ready}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Bad stop bit: one-cycle frame_err, nothing stored.
        err_base = err_cycles;
        send_frame(8'h55, ~(^8'h55), 1'b0);
        chk("badstop_err_cycles", 32'(err_cycles - err_base), 32'd1);
        chk("badstop_ready", {31'd0, ready}, 32'd0);

        // Wrong parity.
        err_base = err_cycles;
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
        chk("parity_err_cycles", 32'(err_cycles - err_base), 32'd1);
        chk("parity_ready", {31'd0, ready}, 32'd0);
`else
        exp_q.push_back(8'h1C);
        chk("parity_err_cycles", 32'(err_cycles - err_base), 32'd0);
        pop_check("parity_ignored");
`endif

        // Partial frame abandoned by timeout.
        err_base = err_cycles;
        send_bits(11'b111_0101_0100, 5);
        wait_clk(TOUT + 10);
        send_good(8'h29, 1'b1);
        pop_check("timeout");
        chk("timeout_empty", {31'd0, ready}, 32'd0);
        chk("timeout_no_err", 32'(err_cycles - err_base), 32'd0);

        // Reset mid-frame.
        err_base = err_cycles;
        send_bits(11'b111_0011_0010, 4);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_data", {24'd0, data}, 32'h00);
        rst = 1'b0;
        wait_clk(2);
        send_good(8'h32, 1'b1);
        pop_check("midrst");
        chk("midrst_no_err", 32'(err_cycles - err_base), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
